// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: default widths, the idle line level and the
// three-input majority vote used by the oversampling front end.
package uart_rx_pkg;

  localparam int   PRESCALE_WIDTH_DEF = 6;
  localparam logic RX_IDLE_LEVEL      = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/data_sampling_if.sv
// Signal bundle between the RX FSM / edge counter (master) and the
// oversampling front end (slave).
interface data_sampling_if
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = PRESCALE_WIDTH_DEF
);

  logic                      rx_in;
  logic                      dat_samp_en;
  logic [Prescale_width-1:0] Prescale;
  logic [Prescale_width-1:0] edge_cnt;
  logic                      sampled_bit;
  logic                      sample_valid;
  logic                      rx_sync;

  modport master (
    output rx_in, dat_samp_en, Prescale, edge_cnt,
    input  sampled_bit, sample_valid, rx_sync
  );

  modport slave (
    input  rx_in, dat_samp_en, Prescale, edge_cnt,
    output sampled_bit, sample_valid, rx_sync
  );

endinterface

// File: rtl/bit_sync.sv
// N-stage flop synchroniser for a single asynchronous input; q is d delayed
// by STAGES clk cycles. Reset loads RST_VAL into every stage.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its neighbour held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/data_sampling.sv
// UART RX oversampling front end: synchronises rx_in, takes three samples
// around mid-bit and registers their majority vote with a one-cycle strobe.
module data_sampling
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = PRESCALE_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input logic            clk,
  input logic            reset,
  data_sampling_if.slave bus
);

  localparam logic [Prescale_width-1:0] ONE = Prescale_width'(1);

  logic                      rx_sync;
  logic [Prescale_width-1:0] mid;
  logic [Prescale_width-1:0] p0;
  logic [Prescale_width-1:0] p1;
  logic [Prescale_width-1:0] p2;
  logic                      s0;
  logic                      s1;
  logic                      v0;
  logic                      v1;
  logic                      sampled_bit;
  logic                      sample_valid;

  bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RX_IDLE_LEVEL)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx_in),
    .q     (rx_sync)
  );

  assign mid = bus.Prescale >> 1;
  assign p0  = mid - ONE;
  assign p1  = mid;
  assign p2  = mid + ONE;

  // v0 -> v1 -> vote: the vote only fires when both earlier sample points
  // were taken during this bit with the enable continuously high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0           <= RX_IDLE_LEVEL;
      s1           <= RX_IDLE_LEVEL;
      v0           <= 1'b0;
      v1           <= 1'b0;
      sampled_bit  <= RX_IDLE_LEVEL;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!bus.dat_samp_en) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
      end else if (bus.edge_cnt == p0) begin
        s0 <= rx_sync;
        v0 <= 1'b1;
      end else if (bus.edge_cnt == p1) begin
        s1 <= rx_sync;
        v1 <= v0;
      end else if (bus.edge_cnt == p2) begin
        if (v1) begin
          sampled_bit  <= maj3(s0, s1, rx_sync);
          sample_valid <= 1'b1;
        end
        v0 <= 1'b0;
        v1 <= 1'b0;
      end
    end
  end

  assign bus.sampled_bit  = sampled_bit;
  assign bus.sample_valid = sample_valid;
  assign bus.rx_sync      = rx_sync;

endmodule

// File: tb/tb_data_sampling.sv
// Directed bench for data_sampling: per-bit stimulus tables with hand-computed
// votes, plus hand-written reset and frame sequences.
module tb_data_sampling;
  import uart_rx_pkg::*;

  localparam int W    = PRESCALE_WIDTH_DEF;
  localparam int SYNC = 2;

  typedef struct {
    int         ps;          // Prescale for this bit
    logic       base;        // line level away from the sample points
    logic [2:0] pts;         // line level at {P0, P1, P2}
    int         off_lo;      // enable low for edge_cnt in [off_lo, off_hi]
    int         off_hi;
    int         exp_strobes;
    logic       exp_bit;     // sampled_bit at the end of this bit
  } bit_vec_t;

  typedef struct {
    logic         en;
    logic [W-1:0] ec;
    logic         lvl;       // level wanted on rx_sync in this cycle
    int           idx;       // owning bit, -1 for idle
  } step_t;

  logic     clk = 1'b0;
  logic     reset = 1'b0;
  int       chk_cnt = 0;
  int       pass_cnt = 0;
  bit_vec_t vecs[$];

  always #5 clk = ~clk;

  data_sampling_if #(.Prescale_width(W)) bus ();

  data_sampling #(
    .Prescale_width (W),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit_vec_t mk(input int ps, input logic base, input logic [2:0] pts,
                                  input int lo, input int hi, input int es, input logic eb);
    bit_vec_t v;
    v.ps = ps; v.base = base; v.pts = pts; v.off_lo = lo; v.off_hi = hi;
    v.exp_strobes = es; v.exp_bit = eb;
    return v;
  endfunction

  task automatic run_scenario(input string name);
    step_t plan[$];
    step_t s;
    int    n, psi, midi;
    int    cnt[];
    logic  endv[];

    n    = vecs.size();
    cnt  = new[n];
    endv = new[n];
    psi  = vecs[0].ps;
    midi = psi >> 1;
    if (!(psi == 8 || psi == 16 || psi == 32)) begin
      $display("FAIL %s.prescale_legal: got %0d expected 8/16/32", name, psi);
      $fatal(1, "illegal Prescale");
    end
    foreach (cnt[i]) begin
      cnt[i]  = 0;
      endv[i] = 1'bx;
    end

    for (int i = 0; i < 4; i++) plan.push_back('{en: 1'b0, ec: '0, lvl: 1'b1, idx: -1});
    for (int v = 0; v < n; v++) begin
      for (int e = 0; e < psi; e++) begin
        s.lvl = vecs[v].base;
        if (e == midi - 1) s.lvl = vecs[v].pts[2];
        if (e == midi)     s.lvl = vecs[v].pts[1];
        if (e == midi + 1) s.lvl = vecs[v].pts[0];
        s.en  = !(e >= vecs[v].off_lo && e <= vecs[v].off_hi);
        s.ec  = W'(e);
        s.idx = v;
        plan.push_back(s);
      end
    end
    for (int i = 0; i < 3; i++) plan.push_back('{en: 1'b0, ec: '0, lvl: 1'b1, idx: -1});

    bus.Prescale = W'(psi);
    for (int t = 0; t < plan.size(); t++) begin
      @(negedge clk);
      bus.dat_samp_en = plan[t].en;
      bus.edge_cnt    = plan[t].ec;
      bus.rx_in       = (t + SYNC < plan.size()) ? plan[t + SYNC].lvl : 1'b1;
      #1;
      if (t >= SYNC) check($sformatf("%s.rx_sync[%0d]", name, t), 32'(bus.rx_sync), 32'(plan[t].lvl));
      if (bus.sample_valid) begin
        if (plan[t].idx < 0) begin
          check($sformatf("%s.stray_strobe[%0d]", name, t), 32'd1, 32'd0);
        end else begin
          cnt[plan[t].idx]++;
          check($sformatf("%s.bit%0d.strobe_pos", name, plan[t].idx), 32'(plan[t].ec), 32'(midi + 2));
        end
      end
      if (plan[t].idx >= 0 && int'(plan[t].ec) == psi - 1) endv[plan[t].idx] = bus.sampled_bit;
    end

    for (int v = 0; v < n; v++) begin
      check($sformatf("%s.bit%0d.strobes", name, v), 32'(cnt[v]), 32'(vecs[v].exp_strobes));
      check($sformatf("%s.bit%0d.value", name, v), 32'(endv[v]), 32'(vecs[v].exp_bit));
    end
  endtask

  initial begin
    logic [9:0] frame;

    bus.rx_in       = 1'b1;
    bus.dat_samp_en = 1'b0;
    bus.Prescale    = W'(8);
    bus.edge_cnt    = '0;
    #1 reset = 1'b1;
    #1;
    check("reset.sampled_bit", 32'(bus.sampled_bit), 32'd1);
    check("reset.sample_valid", 32'(bus.sample_valid), 32'd0);
    check("reset.rx_sync", 32'(bus.rx_sync), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Prescale 8: solid 0, solid 1, single-sample glitches either way.
    vecs.delete();
    vecs.push_back(mk(8, 1'b0, 3'b000, 99, -1, 1, 1'b0));
    vecs.push_back(mk(8, 1'b1, 3'b111, 99, -1, 1, 1'b1));
    vecs.push_back(mk(8, 1'b1, 3'b101, 99, -1, 1, 1'b1));
    vecs.push_back(mk(8, 1'b0, 3'b100, 99, -1, 1, 1'b0));
    run_scenario("ps8");

    // Async reset asserted mid-bit with the line low.
    @(negedge clk);
    bus.rx_in       = 1'b0;
    bus.dat_samp_en = 1'b1;
    bus.edge_cnt    = W'(2);
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset.rx_sync", 32'(bus.rx_sync), 32'd0);
    check("pre_reset.sampled_bit", 32'(bus.sampled_bit), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midbit_reset.sampled_bit", 32'(bus.sampled_bit), 32'd1);
    check("midbit_reset.sample_valid", 32'(bus.sample_valid), 32'd0);
    check("midbit_reset.rx_sync", 32'(bus.rx_sync), 32'd1);
    @(negedge clk);
    check("held_reset.rx_sync", 32'(bus.rx_sync), 32'd1);
    reset           = 1'b0;
    bus.rx_in       = 1'b1;
    bus.dat_samp_en = 1'b0;

    // Prescale 16: 1-clk low at P1 is voted out; two-of-three either way.
    vecs.delete();
    vecs.push_back(mk(16, 1'b1, 3'b101, 99, -1, 1, 1'b1));
    vecs.push_back(mk(16, 1'b0, 3'b011, 99, -1, 1, 1'b1));
    vecs.push_back(mk(16, 1'b1, 3'b100, 99, -1, 1, 1'b0));
    run_scenario("ps16");

    // Prescale 32: samples 0,0,1 then 1,0,1.
    vecs.delete();
    vecs.push_back(mk(32, 1'b0, 3'b001, 99, -1, 1, 1'b0));
    vecs.push_back(mk(32, 1'b1, 3'b101, 99, -1, 1, 1'b1));
    run_scenario("ps32");

    // Enable dropped after P0 / raised after P0: no strobe, value held.
    vecs.delete();
    vecs.push_back(mk(16, 1'b0, 3'b000, 99, -1, 1, 1'b0));
    vecs.push_back(mk(16, 1'b1, 3'b111,  8, 15, 0, 1'b0));
    vecs.push_back(mk(16, 1'b1, 3'b111, 99, -1, 1, 1'b1));
    vecs.push_back(mk(16, 1'b0, 3'b000,  0,  7, 0, 1'b1));
    vecs.push_back(mk(16, 1'b0, 3'b000, 99, -1, 1, 1'b0));
    run_scenario("enable");

    // Frame 0_10110011_1 at Prescale 8, written in line order.
    frame = 10'b0101100111;
    vecs.delete();
    for (int i = 9; i >= 0; i--) begin
      vecs.push_back(mk(8, frame[i], {3{frame[i]}}, 99, -1, 1, frame[i]));
    end
    run_scenario("frame");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
